// File: rtl/instr_fetch.sv
// RV32I instruction fetch: owns the PC, issues credit-limited word reads over req/gnt + rvalid,
// and queues {pc, instr} in order for decode. Redirects flush the queue and drop in-flight replies.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc;
  logic [31:0]   addr_q [DEPTH];
  logic [PW-1:0] addr_wr, addr_rd;
  logic [CW-1:0] outstanding, outstanding_next, discard;

  logic [31:0]   iq_pc    [DEPTH];
  logic [31:0]   iq_instr [DEPTH];
  logic [PW-1:0] iq_wr, iq_rd;
  logic [CW-1:0] iq_count;

  logic [CW:0]   in_use;
  logic          can_fetch, grant, resp, push, pop;

  always_comb begin
    in_use    = {1'b0, iq_count} + {1'b0, outstanding};
    // Credit covers buffered plus in-flight words, so a response always finds a free slot.
    can_fetch = !redirect_valid && (in_use < (CW+1)'(DEPTH));
    imem_req  = rst_n && can_fetch;
    grant     = can_fetch && imem_gnt;
    resp      = imem_rvalid && (outstanding != '0);
    push      = resp && (discard == '0) && !redirect_valid;
    pop       = dec_valid && dec_ready;
    outstanding_next = outstanding;
    if (grant && !resp) begin
      outstanding_next = outstanding + CW'(1);
    end else if (!grant && resp) begin
      outstanding_next = outstanding - CW'(1);
    end
  end

  assign imem_addr = pc;
  assign dec_valid = (iq_count != '0);
  assign dec_pc    = iq_pc[iq_rd];
  assign dec_instr = iq_instr[iq_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      addr_wr     <= '0;
      addr_rd     <= '0;
      outstanding <= '0;
      discard     <= '0;
      iq_wr       <= '0;
      iq_rd       <= '0;
      iq_count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i]   <= '0;
        iq_pc[i]    <= '0;
        iq_instr[i] <= '0;
      end
    end else begin
      if (grant) begin
        addr_q[addr_wr] <= pc;
        addr_wr         <= addr_wr + PW'(1);
      end
      if (resp) begin
        addr_rd <= addr_rd + PW'(1);
      end
      outstanding <= outstanding_next;

      if (redirect_valid) begin
        pc       <= redirect_pc & ~32'h3;
        discard  <= outstanding_next;
        iq_wr    <= '0;
        iq_rd    <= '0;
        iq_count <= '0;
      end else begin
        if (grant) begin
          pc <= pc + 32'd4;
        end
        if (resp && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          iq_pc[iq_wr]    <= addr_q[addr_rd];
          iq_instr[iq_wr] <= imem_rdata;
          iq_wr           <= iq_wr + PW'(1);
        end
        if (pop) begin
          iq_rd <= iq_rd + PW'(1);
        end
        if (push && !pop) begin
          iq_count <= iq_count + CW'(1);
        end else if (!push && pop) begin
          iq_count <= iq_count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model of fetch/decode plus an in-order memory
// with per-request latency; each scenario task compares DUT outputs against the model every cycle.
module tb_instr_fetch;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, dec_valid, dec_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, dec_instr, dec_pc;

  logic        w_req, w_gnt, w_rvalid, w_redirect_valid, w_dv, w_ready;
  logic [31:0] w_addr, w_rdata, w_redirect_pc, w_instr, w_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
  );

  instr_fetch #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .dec_valid(w_dv), .dec_ready(w_ready), .dec_instr(w_instr), .dec_pc(w_pc)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;
  logic [31:0] mem_mask = 32'h0, mem_salt = 32'h13;

  typedef struct { int unsigned due; logic [31:0] addr; } resp_t;
  resp_t       mem_q[$];
  logic [31:0] m_aq[$];
  logic [63:0] m_iq[$];
  logic [31:0] m_pc;
  int unsigned m_out, m_disc;

  function automatic logic exp_req();
    return !redirect_valid && ((m_iq.size() + m_out) < DEPTH);
  endfunction

  function automatic logic [97:0] expv();
    logic [63:0] h;
    h = 64'h0;
    if (m_iq.size() != 0) h = m_iq[0];
    return {exp_req(), m_pc, m_iq.size() != 0, h};
  endfunction

  function automatic logic [97:0] obsv();
    logic [63:0] h;
    h = 64'h0;
    if (m_iq.size() != 0) h = {dec_pc, dec_instr};
    return {imem_req, imem_addr, dec_valid, h};
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a & mem_mask) ^ mem_salt;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_out = 0; m_disc = 0;
    m_aq.delete(); m_iq.delete(); mem_q.delete();
  endtask

  task automatic drive_mem(input bit spurious);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(mem_q[0].addr);
    end else if (spurious && mem_q.size() == 0) begin
      imem_rvalid = 1'b1;
    end
  endtask

  // Advance one clock: memory and model consume the inputs held across the edge.
  task automatic tick();
    bit g, r, pop, red;
    logic [31:0] rpc, rdat, a;
    g = exp_req() && imem_gnt;
    r = imem_rvalid && (m_out != 0);
    pop = (m_iq.size() != 0) && dec_ready;
    red = redirect_valid; rpc = redirect_pc; rdat = imem_rdata;
    @(posedge clk);
    if (imem_rvalid && mem_q.size() != 0) void'(mem_q.pop_front());
    if (g) mem_q.push_back('{cyc + $urandom_range(lat_max, lat_min), m_pc});
    if (pop) void'(m_iq.pop_front());
    if (r) begin
      a = m_aq.pop_front();
      if (!red) begin
        if (m_disc != 0) m_disc--;
        else m_iq.push_back({a, rdat});
      end
    end
    if (g) begin m_aq.push_back(m_pc); m_pc += 32'd4; m_out++; end
    if (r) m_out--;
    if (red) begin m_iq.delete(); m_disc = m_out; m_pc = {rpc[31:2], 2'b00}; end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; dec_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    w_gnt = 0; w_rvalid = 0; w_rdata = 0; w_redirect_valid = 0; w_redirect_pc = 0; w_ready = 0;
    #1 rst_n = 1'b0;
    #1;
    if ({imem_req, dec_valid, dec_pc, dec_instr} !== 66'h0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b dv=%b pc=%h instr=%h exp all zero",
               imem_req, dec_valid, dec_pc, dec_instr);
    end
    checks++;
    imem_gnt = 1'b1;
    @(negedge clk);
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req_held got=%b exp=0", imem_req);
    end
    checks++;
    model_reset();
    rst_n = 1'b1;
    imem_gnt = 1'b0;
    drive_mem(0); #1;
    if (obsv() !== expv()) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", obsv(), expv());
    end
    checks++;
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    imem_gnt = 1; dec_ready = 1; lat_min = 1; lat_max = 1; mem_mask = 32'h0; mem_salt = 32'h13;
    for (int i = 0; i < 12; i++) begin
      drive_mem(0); #1;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int unsigned grants;
    do_reset();
    imem_gnt = 1; dec_ready = 0; mem_mask = '1; mem_salt = 32'h5A5A_0000;
    grants = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        if (grants !== 2) begin
          errors++; $display("FAIL backpressure_grants got=%0d exp=2", grants);
        end
        checks++;
        dec_ready = 1;
      end
      drive_mem(0); #1;
      if (imem_req && imem_gnt) grants++;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_redirect();
    bit seen;
    logic [31:0] first_pc;
    do_reset();
    imem_gnt = 1; dec_ready = 1; lat_min = 3; lat_max = 3; mem_salt = 32'hC0DE_0000;
    seen = 0; first_pc = '1;
    for (int i = 0; i < 14; i++) begin
      redirect_valid = (i == 2);
      redirect_pc    = 32'h0000_0102;
      drive_mem(0); #1;
      if (i > 2 && dec_valid && !seen) begin seen = 1; first_pc = dec_pc; end
      if (obsv() !== expv()) begin
        errors++; $display("FAIL redirect cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
      end
      checks++;
      tick();
    end
    redirect_valid = 0;
    if (first_pc !== 32'h0000_0100) begin
      errors++; $display("FAIL redirect_first_pc got=%h exp=00000100", first_pc);
    end
    checks++;
  endtask

  task automatic test_redirect_collide();
    bit done;
    int red_i;
    do_reset();
    imem_gnt = 1; dec_ready = 1; lat_min = 1; lat_max = 1; mem_salt = 32'h0BAD_0000;
    done = 0; red_i = -10;
    for (int i = 0; i < 12; i++) begin
      drive_mem(0);
      redirect_valid = !done && imem_rvalid && (m_iq.size() != 0);
      redirect_pc    = 32'h0000_0100;
      if (redirect_valid) begin done = 1; red_i = i; end
      #1;
      if (i == red_i + 1) begin
        if (dec_valid !== 1'b0) begin
          errors++; $display("FAIL collide_flush got dv=%b exp=0", dec_valid);
        end
        checks++;
      end
      if (obsv() !== expv()) begin
        errors++; $display("FAIL collide cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
      end
      checks++;
      tick();
    end
    redirect_valid = 0;
    if (!done) begin
      errors++; $display("FAIL collide_setup got=0 exp=1 (no rvalid+handshake cycle)");
    end
    checks++;
  endtask

  task automatic test_spurious();
    do_reset();
    dec_ready = 1; mem_salt = 32'h7777_0000;
    for (int i = 0; i < 6; i++) begin
      imem_gnt = (i != 0);
      drive_mem(i == 0); #1;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL spurious cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 4; mem_mask = '1; mem_salt = $urandom;
    for (int i = 0; i < 400; i++) begin
      imem_gnt       = ($urandom_range(0, 3) != 0);
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ((i % 100) == 50) || ((i % 100) == 51) || ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      drive_mem($urandom_range(0, 9) == 0); #1;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
      end
      checks++;
      tick();
    end
    redirect_valid = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_gnt = 1; dec_ready = 1; lat_min = 3; lat_max = 3; mem_salt = 32'h1111_0000;
    for (int i = 0; i < 5; i++) begin
      drive_mem(0); #1;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL async_pre cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
      end
      checks++;
      if (i < 4) tick();
    end
    #2 rst_n = 1'b0;
    #1;
    if ({imem_req, dec_valid, dec_pc, dec_instr} !== 66'h0) begin
      errors++;
      $display("FAIL async_drop got req=%b dv=%b pc=%h instr=%h exp all zero",
               imem_req, dec_valid, dec_pc, dec_instr);
    end
    checks++;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) begin
      drive_mem(0); #1;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL async_post cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wq[$];
    logic [31:0] ea, ed, ga;
    int unsigned grants;
    bit g, rv;
    ea = WRAP_PC; ed = WRAP_PC; grants = 0;
    w_gnt = 1; w_ready = 1;
    for (int i = 0; i < 10; i++) begin
      w_rvalid = (wq.size() != 0);
      w_rdata  = (wq.size() != 0) ? ~wq[0] : 32'h0;
      #1;
      if (w_req) begin
        if (w_addr !== ea) begin
          errors++; $display("FAIL wrap_addr got=%h exp=%h", w_addr, ea);
        end
        checks++;
        ea += 32'd4; grants++;
      end
      if (w_dv) begin
        if ({w_pc, w_instr} !== {ed, ~ed}) begin
          errors++; $display("FAIL wrap_dec got=%h/%h exp=%h/%h", w_pc, w_instr, ed, ~ed);
        end
        checks++;
        ed += 32'd4;
      end
      g = w_req && w_gnt; rv = w_rvalid; ga = w_addr;
      @(posedge clk);
      if (rv) void'(wq.pop_front());
      if (g) wq.push_back(ga);
      @(negedge clk);
    end
    if (grants < 3) begin
      errors++; $display("FAIL wrap_progress got=%0d exp>=3", grants);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_spurious();
    test_random();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
